winograd_dot_ctrl: RTL

//  Sequencer wrapping one winograd pair-product unit. Runs a signed dot-product
//  job of cfg_beats_i beats; each beat carries 8 operands per side.

---
 rtl/winograd_pkg.sv | 27 ++
 rtl/winograd_dot_ctrl_unit.sv | 67 ++++++
 rtl/winograd_dot_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/winograd_pkg.sv
// winograd_pkg
//   Shared types and width helpers for the winograd dot-product controller
//   and its pair-product datapath.
//   - ctrl_state_e : controller FSM states
//   - N_OPS        : operands per side in one beat
//   - out_size_f   : width of one datapath output lane
//   - acc_size_f   : accumulator width wide enough for max_beats full-scale beats
package winograd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      OUTPUT = 2'd3
   } ctrl_state_e;

   localparam int N_OPS = 8;

   function automatic int out_size_f(input int in_size_1);
      return 2 * (in_size_1 + 1) + 6;
   endfunction

   function automatic int acc_size_f(input int out_size, input int max_beats);
      return out_size + $clog2(max_beats) + 1;
   endfunction

endpackage

// File: rtl/winograd_dot_ctrl_unit.sv
// winograd_dot_ctrl_unit
//   Winograd pair-product datapath, three register stages, free running.
//   Per pair k: p[k] = (a[2k+1] + b[2k]) * (a[2k] + b[2k+1]) (all signed).
//   out_o[0] = p[0] + p[1], out_o[1] = p[2] + p[3].
//   Ports:
//     clk_i, rst_ni : clock, asynchronous active-low reset
//     in_0_i        : 8 signed operands, side a
//     in_1_i        : 8 signed operands, side b
//     out_o         : 2 signed lanes, valid three edges after the input sample edge
module winograd_dot_ctrl_unit
   import winograd_pkg::*;
#(
   parameter  int IN_SIZE_0 = 8,
   parameter  int IN_SIZE_1 = 8,
   localparam int OUT_SIZE  = out_size_f(IN_SIZE_1)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [N_OPS-1:0][IN_SIZE_0-1:0]   in_0_i,
   input  logic [N_OPS-1:0][IN_SIZE_1-1:0]   in_1_i,
   output logic [1:0][OUT_SIZE-1:0]          out_o
);

   localparam int SUM_W   = ((IN_SIZE_0 > IN_SIZE_1) ? IN_SIZE_0 : IN_SIZE_1) + 1;
   localparam int PROD_W  = 2 * SUM_W;
   localparam int N_PAIRS = N_OPS / 2;

   logic [N_OPS-1:0][IN_SIZE_0-1:0]  a_q;
   logic [N_OPS-1:0][IN_SIZE_1-1:0]  b_q;
   logic [N_PAIRS-1:0][SUM_W-1:0]    sa_d, sb_d, sa_q, sb_q;
   logic [N_PAIRS-1:0][PROD_W-1:0]   prod_s;
   logic [1:0][OUT_SIZE-1:0]         out_d, out_q;

   // Cross pair sums, products and lane reduction between the stage registers.
   always_comb begin
      sa_d   = '0;
      sb_d   = '0;
      prod_s = '0;
      for (int k = 0; k < N_PAIRS; k++) begin
         sa_d[k]   = SUM_W'($signed(a_q[2*k+1])) + SUM_W'($signed(b_q[2*k]));
         sb_d[k]   = SUM_W'($signed(a_q[2*k])) + SUM_W'($signed(b_q[2*k+1]));
         prod_s[k] = PROD_W'($signed(sa_q[k])) * PROD_W'($signed(sb_q[k]));
      end
      out_d[0] = OUT_SIZE'($signed(prod_s[0])) + OUT_SIZE'($signed(prod_s[1]));
      out_d[1] = OUT_SIZE'($signed(prod_s[2])) + OUT_SIZE'($signed(prod_s[3]));
   end

   // Three pipeline stages: operands, pair sums, reduced products.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q   <= '0;
         b_q   <= '0;
         sa_q  <= '0;
         sb_q  <= '0;
         out_q <= '0;
      end else begin
         a_q   <= in_0_i;
         b_q   <= in_1_i;
         sa_q  <= sa_d;
         sb_q  <= sb_d;
         out_q <= out_d;
      end
   end

   assign out_o = out_q;

endmodule

// File: rtl/winograd_dot_ctrl.sv
// winograd_dot_ctrl
//   Sequences one signed dot-product job of cfg_beats_i beats through the
//   winograd datapath, accumulates both output lanes of every valid beat and
//   returns a single result over valid/ready.
//   Ports:
//     clk_i, rst_ni          : clock, asynchronous active-low reset
//     clr_i                  : synchronous abort, overrides every other input
//     start_i, cfg_beats_i   : job start (IDLE only) and beat count (clamped to MAX_BEATS)
//     busy_o                 : controller not idle
//     in_valid_i, in_ready_o : operand beat handshake (ready only while streaming)
//     in_0_i, in_1_i         : beat operands
//     res_valid_o, res_ready_i, res_data_o : job result handshake and data
//     done_o                 : one-cycle pulse after the result handshake
module winograd_dot_ctrl
   import winograd_pkg::*;
#(
   parameter  int IN_SIZE_0  = 8,
   parameter  int IN_SIZE_1  = 8,
   parameter  int MAX_BEATS  = 16,
   parameter  int DP_LATENCY = 3,
   localparam int OUT_SIZE   = out_size_f(IN_SIZE_1),
   localparam int ACC_SIZE   = acc_size_f(OUT_SIZE, MAX_BEATS),
   localparam int CNT_W      = $clog2(MAX_BEATS + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             clr_i,
   input  logic                             start_i,
   input  logic [CNT_W-1:0]                 cfg_beats_i,
   output logic                             busy_o,
   input  logic                             in_valid_i,
   output logic                             in_ready_o,
   input  logic [N_OPS-1:0][IN_SIZE_0-1:0]  in_0_i,
   input  logic [N_OPS-1:0][IN_SIZE_1-1:0]  in_1_i,
   output logic                             res_valid_o,
   input  logic                             res_ready_i,
   output logic [ACC_SIZE-1:0]              res_data_o,
   output logic                             done_o
);

   // Only the oldest in-flight tag set: its product is the last one still due.
   localparam logic [DP_LATENCY-1:0] TAIL_ONLY = DP_LATENCY'(1) << (DP_LATENCY - 1);

   ctrl_state_e                      state_q, state_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [DP_LATENCY-1:0]            tag_q, tag_d;
   logic [ACC_SIZE-1:0]              acc_q, acc_d;
   logic                             done_q, done_d;
   logic                             accept_s;
   logic [CNT_W-1:0]                 beats_s;
   logic [ACC_SIZE-1:0]              beat_sum_s;
   logic [N_OPS-1:0][IN_SIZE_0-1:0]  dp_0_s;
   logic [N_OPS-1:0][IN_SIZE_1-1:0]  dp_1_s;
   logic [1:0][OUT_SIZE-1:0]         dp_out_s;

   assign accept_s = (state_q == STREAM) && in_valid_i;
   assign beats_s  = (cfg_beats_i > CNT_W'(MAX_BEATS)) ? CNT_W'(MAX_BEATS) : cfg_beats_i;

   // Bubbles are injected as zero operands; their tag is 0 so they are never summed.
   assign dp_0_s = accept_s ? in_0_i : '0;
   assign dp_1_s = accept_s ? in_1_i : '0;

   winograd_dot_ctrl_unit #(
      .IN_SIZE_0 (IN_SIZE_0),
      .IN_SIZE_1 (IN_SIZE_1)
   ) u_unit (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .in_0_i (dp_0_s),
      .in_1_i (dp_1_s),
      .out_o  (dp_out_s)
   );

   assign beat_sum_s = ACC_SIZE'($signed(dp_out_s[0])) + ACC_SIZE'($signed(dp_out_s[1]));

   // Next-state logic: FSM, remaining-beat counter, tag shift register and accumulator.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tag_d   = (tag_q << 1'b1) | DP_LATENCY'(accept_s);
      acc_d   = tag_q[DP_LATENCY-1] ? (acc_q + beat_sum_s) : acc_q;
      done_d  = 1'b0;
      if (clr_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         tag_d   = '0;
         acc_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  acc_d = '0;
                  if (beats_s == CNT_W'(0)) begin
                     state_d = OUTPUT;
                  end else begin
                     state_d = STREAM;
                     cnt_d   = beats_s;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            STREAM: begin
               if (accept_s) begin
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = DRAIN;
                  end else begin
                     state_d = STREAM;
                  end
               end else begin
                  state_d = STREAM;
               end
            end
            DRAIN: begin
               // No new beats enter here, so the tail-only pattern marks the final product.
               if (tag_q == TAIL_ONLY) begin
                  state_d = OUTPUT;
               end else begin
                  state_d = DRAIN;
               end
            end
            OUTPUT: begin
               if (res_ready_i) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = OUTPUT;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, counter, tags, accumulator and done pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tag_q   <= '0;
         acc_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign in_ready_o  = (state_q == STREAM);
   assign res_valid_o = (state_q == OUTPUT);
   assign res_data_o  = acc_q;
   assign done_o      = done_q;

endmodule
